// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared op codes, M funct3 codes and FSM encoding for the execute stage
package ex_pkg;

  localparam int OP_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SRL   = 4'd5,
    ALU_OR    = 4'd6,
    ALU_AND   = 4'd7,
    ALU_BEQ   = 4'd8,
    ALU_BNE   = 4'd9,
    ALU_BLT   = 4'd10,
    ALU_BGE   = 4'd11,
    ALU_PASSB = 4'd12
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_funct3_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  function automatic logic md_a_signed(input logic [2:0] f3);
    return f3 inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_b_signed(input logic [2:0] f3);
    return f3 inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// rtl/ex_stage_md_if.sv - operand/result handshake bundle between ID/EX and EX/MEM
interface ex_stage_md_if #(parameter int XLEN = 32) ();
  import ex_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic            alu_src_a;
  logic            alu_src_b;
  logic            is_signed;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] sext;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            branch_result;

  modport master (
    output in_valid, alu_src_a, alu_src_b, is_signed, op, pc, a, b, sext, out_ready,
    input  in_ready, out_valid, alu_result, branch_result
  );

  modport slave (
    input  in_valid, alu_src_a, alu_src_b, is_signed, op, pc, a, b, sext, out_ready,
    output in_ready, out_valid, alu_result, branch_result
  );

endinterface

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - single-cycle base ALU; branch ops return the sum as target and the compare as outcome
module ex_alu import ex_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      op_i,
  input  logic            is_signed_i,
  output logic [XLEN-1:0] result_o,
  output logic            branch_o
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] sra;
  logic            lt;
  logic            eq;

  assign shamt = b_i[SHW-1:0];
  assign sum   = a_i + b_i;
  // kept as its own signal so the shift stays arithmetic regardless of the surrounding mux
  assign sra   = $signed(a_i) >>> shamt;
  assign lt    = is_signed_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
  assign eq    = (a_i == b_i);

  always_comb begin
    result_o = '0;
    branch_o = 1'b0;
    case (op_i)
      ALU_ADD:   result_o = sum;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, lt};
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SRL:   result_o = is_signed_i ? sra : (a_i >> shamt);
      ALU_OR:    result_o = a_i | b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_BEQ:   begin result_o = sum; branch_o = eq;  end
      ALU_BNE:   begin result_o = sum; branch_o = !eq; end
      ALU_BLT:   begin result_o = sum; branch_o = lt;  end
      ALU_BGE:   begin result_o = sum; branch_o = !lt; end
      ALU_PASSB: result_o = b_i;
      default:   ;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - counted multiplier and restoring divider with sign fixup for RV32M ops
module ex_muldiv import ex_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam bit MUL_COMB = (MUL_LAT == 1);

  logic            busy_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q, rem_q, quo_q;
  logic [CW-1:0]   cnt_q;

  logic [2:0]        f3_m;
  logic [XLEN-1:0]   ma, mb, mul_res, a_mag_in;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic              sa, sb, b_zero, start_seq, is_div;
  logic [XLEN-1:0]   bmag, rem_n, quo_n, q_fix, r_fix, div_res;
  logic [XLEN:0]     rem_sh, diff;

  // a single-cycle multiply completes straight from the live operands
  assign f3_m  = busy_q ? f3_q : funct3_i;
  assign ma    = busy_q ? a_q : a_i;
  assign mb    = busy_q ? b_q : b_i;
  assign ext_a = {{XLEN{md_a_signed(f3_m) & ma[XLEN-1]}}, ma};
  assign ext_b = {{XLEN{md_b_signed(f3_m) & mb[XLEN-1]}}, mb};
  assign prod  = ext_a * ext_b;
  assign mul_res = (f3_m == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign sa     = md_a_signed(f3_q) & a_q[XLEN-1];
  assign sb     = md_b_signed(f3_q) & b_q[XLEN-1];
  assign b_zero = (b_q == '0);
  assign bmag   = sb ? -b_q : b_q;
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, bmag};
  assign rem_n  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_n  = {quo_q[XLEN-2:0], ~diff[XLEN]};
  assign q_fix  = (sa ^ sb) ? -quo_n : quo_n;
  assign r_fix  = sa ? -rem_n : rem_n;
  assign div_res = f3_q[1] ? (b_zero ? a_q : r_fix) : (b_zero ? '1 : q_fix);

  assign a_mag_in  = (md_a_signed(funct3_i) & a_i[XLEN-1]) ? -a_i : a_i;
  assign start_seq = start_i & ~(MUL_COMB & ~funct3_i[2]);
  assign is_div    = busy_q ? f3_q[2] : funct3_i[2];
  assign done_o    = (start_i & MUL_COMB & ~funct3_i[2])
                   | (busy_q & (cnt_q == (f3_q[2] ? DIV_LAST : MUL_LAST)));
  assign result_o  = is_div ? div_res : mul_res;
  assign busy_o    = busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      f3_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
    end else if (kill_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_seq) begin
      busy_q <= 1'b1;
      f3_q   <= funct3_i;
      a_q    <= a_i;
      b_q    <= b_i;
      rem_q  <= '0;
      quo_q  <= a_mag_in;
      // multiply counts from the accept cycle, divide counts iterations
      cnt_q  <= funct3_i[2] ? '0 : CW'(1);
    end else if (busy_q) begin
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        if (f3_q[2]) begin
          rem_q <= rem_n;
          quo_q <= quo_n;
        end
      end
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage with registered base-ALU result and stalling RV32M path
module ex_stage_md import ex_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  ex_stage_md_if.slave  bus
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            branch_q, branch_d;

  logic [XLEN-1:0] alu_a, alu_b, alu_res, md_result;
  logic            alu_br, md_busy, md_done;
  logic            out_valid, in_ready, accept, is_m, md_start;

  assign alu_a     = bus.alu_src_a ? bus.a : bus.pc;
  assign alu_b     = bus.alu_src_b ? bus.sext : bus.b;
  assign is_m      = bus.op[4];
  assign out_valid = (state_q == S_DONE);
  // DONE also accepts so a draining result can be replaced without a bubble
  assign in_ready  = (state_q == S_IDLE || state_q == S_DONE) && !md_busy
                   && (!out_valid || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign md_start  = accept && is_m && !flush;

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.alu_result    = result_q;
  assign bus.branch_result = branch_q;

  ex_alu #(.XLEN(XLEN)) u_alu (
    .a_i         (alu_a),
    .b_i         (alu_b),
    .op_i        (bus.op[3:0]),
    .is_signed_i (bus.is_signed),
    .result_o    (alu_res),
    .branch_o    (alu_br)
  );

  ex_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) u_muldiv (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .kill_i   (flush),
    .start_i  (md_start),
    .funct3_i (bus.op[2:0]),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (!is_m) begin
              state_d  = S_DONE;
              result_d = alu_res;
              branch_d = alu_br;
            end else if (md_done) begin
              state_d  = S_DONE;
              result_d = md_result;
              branch_d = 1'b0;
            end else begin
              state_d = bus.op[2] ? S_DIV : S_MUL;
            end
          end else if (bus.out_ready) begin
            state_d = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (md_done) begin
            state_d  = S_DONE;
            result_d = md_result;
            branch_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - directed self-checking bench for ex_stage_md
module tb_ex_stage_md;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 4;

  logic clk;
  logic rst_n;
  logic flush;
  int   errors;
  int   checks;
  logic saw_valid;

  ex_stage_md_if #(.XLEN(XLEN)) bus ();

  ex_stage_md #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] o, input logic sa, input logic sb, input logic sg,
                       input logic [31:0] pcv, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] sv);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.alu_src_a = sa;
    bus.alu_src_b = sb;
    bus.is_signed = sg;
    bus.pc        = pcv;
    bus.a         = av;
    bus.b         = bv;
    bus.sext      = sv;
  endtask

  task automatic run_md(input string tag, input logic [4:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input logic [31:0] exp);
    logic early;
    early = 1'b0;
    @(negedge clk);
    drive(o, 1'b1, 1'b0, 1'b0, 32'h0, av, bv, 32'h0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({tag, ".busy_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h1234_5678;
      end
      early = early | bus.out_valid;
    end
    chk({tag, ".early_valid"}, {31'b0, early}, 32'd0);
    @(negedge clk);
    chk({tag, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({tag, ".result"}, bus.alu_result, exp);
    chk({tag, ".branch"}, {31'b0, bus.branch_result}, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset.result", bus.alu_result, 32'h0);
    chk("reset.branch", {31'b0, bus.branch_result}, 32'd0);
    chk("reset.in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;

    // back-to-back base ops, one result per cycle
    @(negedge clk);
    drive(5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd5, 32'd0, 32'd7);
    @(negedge clk);
    chk("add.valid", {31'b0, bus.out_valid}, 32'd1);
    chk("add.result", bus.alu_result, 32'd12);
    chk("add.in_ready", {31'b0, bus.in_ready}, 32'd1);
    drive(5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'd20, 32'd3, 32'd0);
    @(negedge clk);
    chk("sub.result", bus.alu_result, 32'd17);
    chk("sub.in_ready", {31'b0, bus.in_ready}, 32'd1);
    drive(5'd3, 1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    @(negedge clk);
    chk("slt_s.result", bus.alu_result, 32'd1);
    drive(5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    @(negedge clk);
    chk("slt_u.result", bus.alu_result, 32'd0);
    drive(5'd10, 1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFE, 32'd3, 32'd0);
    @(negedge clk);
    chk("blt.branch", {31'b0, bus.branch_result}, 32'd1);
    chk("blt.result", bus.alu_result, 32'd1);
    drive(5'd5, 1'b1, 1'b0, 1'b1, 32'h0, 32'h8000_0000, 32'd4, 32'd0);
    @(negedge clk);
    chk("sra.result", bus.alu_result, 32'hF800_0000);
    chk("sra.branch", {31'b0, bus.branch_result}, 32'd0);
    drive(5'd0, 1'b0, 1'b1, 1'b0, 32'h1000, 32'd99, 32'd0, 32'd4);
    @(negedge clk);
    chk("pc_add.result", bus.alu_result, 32'h1004);
    chk("pc_add.valid", {31'b0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("drain.valid", {31'b0, bus.out_valid}, 32'd0);

    // multiply and divide, latency measured from the accept cycle
    run_md("mulh", 5'b10001, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000);
    run_md("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'h0000_0001);
    run_md("mul", 5'b10000, 32'hFFFF_FFFD, 32'd7, MUL_LAT, 32'hFFFF_FFEB);
    run_md("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFF);
    run_md("div", 5'b10100, 32'hFFFF_FFF9, 32'd2, XLEN + 1, 32'hFFFF_FFFD);
    run_md("rem", 5'b10110, 32'hFFFF_FFF9, 32'd2, XLEN + 1, 32'hFFFF_FFFF);
    run_md("divu_by0", 5'b10101, 32'h1234_5678, 32'd0, XLEN + 1, 32'hFFFF_FFFF);
    run_md("rem_by0", 5'b10110, 32'd9, 32'd0, XLEN + 1, 32'd9);
    run_md("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, XLEN + 1, 32'h8000_0000);
    run_md("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, XLEN + 1, 32'h0);
    run_md("divu", 5'b10101, 32'd100, 32'd7, XLEN + 1, 32'd14);

    // hold while downstream stalls, then replace in the release cycle
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd1, 32'd0, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold.valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold.result", bus.alu_result, 32'd3);
      chk("hold.in_ready", {31'b0, bus.in_ready}, 32'd0);
      if (i == 0) drive(5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd10, 32'd0, 32'd20);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release.in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    chk("release.valid", {31'b0, bus.out_valid}, 32'd1);
    chk("release.result", bus.alu_result, 32'd30);
    bus.in_valid = 1'b0;

    // flush during the tenth divide cycle
    @(negedge clk);
    drive(5'b10100, 1'b1, 1'b0, 1'b0, 32'h0, 32'd100, 32'd7, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush.in_ready", {31'b0, bus.in_ready}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | bus.out_valid;
    end
    chk("flush.no_stale", {31'b0, saw_valid}, 32'd0);

    // an accept in the flush cycle is discarded
    drive(5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd4, 32'd0, 32'd4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_accept.valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_accept.result", bus.alu_result, 32'd30);

    // reset in the middle of a multiply
    @(negedge clk);
    drive(5'b10000, 1'b1, 1'b0, 1'b0, 32'h0, 32'd3, 32'd5, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid.valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_mid.in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_mid.result", bus.alu_result, 32'h0);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | bus.out_valid;
    end
    chk("rst_mid.no_stale", {31'b0, saw_valid}, 32'd0);
    run_md("mul_after_rst", 5'b10000, 32'd3, 32'd5, MUL_LAT, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
